// File: rtl/pixbuf_pkg.sv
// rtl/pixbuf_pkg.sv - shared types and defaults for the pixel line buffer
//
// Purpose: write-FSM state encoding and default geometry constants.
// Ports:   none (package).

package pixbuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // between lines, waiting for DE
    ST_CAPT = 2'd1,  // storing the active line into the current slot
    ST_SKIP = 2'd2   // discarding the rest of an unwanted line
  } wr_state_t;

  localparam int DEF_DW     = 24;
  localparam int DEF_LINE_W = 256;
  localparam int DEF_NLINES = 4;

endpackage

// File: rtl/dpram.sv
// rtl/dpram.sv - simple dual-port RAM, port 1 write, port 2 registered read
//
// Purpose: line storage for pixel_line_buffer.
// Ports:
//   clk           clock
//   rst_n         async active-low reset of the read register only
//   clr           synchronous clear of the read register
//   we1/addr1/data1  write port
//   addr2/q2      read port, q2 valid one cycle after addr2

module dpram #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] data1,
  input  logic [AWIDTH-1:0] addr2,
  output logic [DWIDTH-1:0] q2
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (we1) mem[addr1] <= data1;
  end

  // The array itself is never reset; only the output register is, so the
  // read data is well defined from reset onwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q2 <= '0;
    else if (clr) q2 <= '0;
    else          q2 <= mem[addr2];
  end

endmodule

// File: rtl/pixel_line_buffer.sv
// rtl/pixel_line_buffer.sv - ring of whole-line slots for a CE-qualified video stream
//
// Purpose: captures active lines (CE/DE/PIX) into NLINES slots of up to
// LINE_W pixels and offers the oldest committed line to a line-granular reader.
// Ports:
//   CLK, nRES        clock, async active-low reset
//   CE, DE, PIX      pixel enable, display enable, pixel data
//   CLR              synchronous flush of slots and sticky flags
//   RVALID, RLEN     oldest line present / its pixel count
//   RADDR, RDATA     pixel index into oldest line / data one cycle later
//   RDONE            releases the oldest line
//   COUNT            committed lines held
//   OVF, TRUNC       sticky: line dropped (full) / line longer than LINE_W

module pixel_line_buffer
  import pixbuf_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int LINE_W = DEF_LINE_W,
  parameter int NLINES = DEF_NLINES,
  parameter int LW     = $clog2(LINE_W + 1)
) (
  input  logic                        CLK,
  input  logic                        nRES,
  input  logic                        CE,
  input  logic                        DE,
  input  logic [DW-1:0]               PIX,
  input  logic                        CLR,
  output logic                        RVALID,
  output logic [LW-1:0]               RLEN,
  input  logic [LW-2:0]               RADDR,
  output logic [DW-1:0]               RDATA,
  input  logic                        RDONE,
  output logic [$clog2(NLINES+1)-1:0] COUNT,
  output logic                        OVF,
  output logic                        TRUNC
);

  // LINE_W is a power of two, so the pixel field is LW-1 bits wide.
  localparam int PW = $clog2(LINE_W);
  localparam int SW = $clog2(NLINES);
  localparam int CW = $clog2(NLINES + 1);
  localparam int AW = SW + PW;

  wr_state_t       state;
  logic [SW-1:0]   wptr;
  logic [SW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic [LW-1:0]   wcnt;
  logic [LW-1:0]   len [NLINES];
  logic            ovf;
  logic            trunc;

  logic            full;
  logic            commit;
  logic            release_line;
  logic            mem_we;
  logic [PW-1:0]   wpix;
  logic [AW-1:0]   mem_waddr;

  always_comb begin
    full         = (count == CW'(NLINES));
    commit       = CE && !DE && (state == ST_CAPT);
    release_line = RDONE && (count != '0);
    // First pixel of a line always lands at index 0 of the slot.
    wpix         = (state == ST_IDLE) ? '0 : wcnt[PW-1:0];
    mem_waddr    = {wptr, wpix};
    mem_we       = !CLR && CE && DE &&
                   (((state == ST_IDLE) && !full) ||
                    ((state == ST_CAPT) && (wcnt < LW'(LINE_W))));
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state <= ST_IDLE;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      wcnt  <= '0;
      ovf   <= 1'b0;
      trunc <= 1'b0;
      for (int i = 0; i < NLINES; i++) len[i] <= '0;
    end else if (CLR) begin
      // A flush in mid-line must not capture the tail of that line.
      state <= DE ? ST_SKIP : ST_IDLE;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      wcnt  <= '0;
      ovf   <= 1'b0;
      trunc <= 1'b0;
      for (int i = 0; i < NLINES; i++) len[i] <= '0;
    end else begin
      if (commit) begin
        len[wptr] <= wcnt;
        wptr      <= wptr + SW'(1);
      end
      if (release_line) rptr <= rptr + SW'(1);
      count <= count + CW'(commit) - CW'(release_line);

      if (CE) begin
        case (state)
          ST_IDLE: begin
            if (DE) begin
              // Admission is decided at line start, so a commit can never
              // find the ring full.
              if (full) begin
                state <= ST_SKIP;
                ovf   <= 1'b1;
              end else begin
                state <= ST_CAPT;
                wcnt  <= LW'(1);
              end
            end
          end
          ST_CAPT: begin
            if (DE) begin
              if (wcnt < LW'(LINE_W)) wcnt  <= wcnt + LW'(1);
              else                    trunc <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_SKIP: begin
            if (!DE) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  dpram #(
    .AWIDTH (AW),
    .DWIDTH (DW)
  ) u_ram (
    .clk   (CLK),
    .rst_n (nRES),
    .clr   (CLR),
    .we1   (mem_we),
    .addr1 (mem_waddr),
    .data1 (PIX),
    .addr2 ({rptr, RADDR}),
    .q2    (RDATA)
  );

  assign RVALID = (count != '0);
  assign RLEN   = len[rptr];
  assign COUNT  = count;
  assign OVF    = ovf;
  assign TRUNC  = trunc;

endmodule

// File: tb/tb_pixel_line_buffer.sv
// tb/tb_pixel_line_buffer.sv - self-checking bench for pixel_line_buffer

module tb_pixel_line_buffer;

  localparam int DW     = 24;
  localparam int LINE_W = 16;
  localparam int NLINES = 4;
  localparam int LW     = $clog2(LINE_W + 1);
  localparam int CW     = $clog2(NLINES + 1);

  logic          CLK = 1'b0;
  logic          nRES, CE, DE, CLR, RDONE;
  logic [DW-1:0] PIX;
  logic [LW-2:0] RADDR;
  logic          RVALID, OVF, TRUNC;
  logic [LW-1:0] RLEN;
  logic [DW-1:0] RDATA;
  logic [CW-1:0] COUNT;

  pixel_line_buffer #(
    .DW (DW), .LINE_W (LINE_W), .NLINES (NLINES)
  ) dut (
    .CLK (CLK), .nRES (nRES), .CE (CE), .DE (DE), .PIX (PIX), .CLR (CLR),
    .RVALID (RVALID), .RLEN (RLEN), .RADDR (RADDR), .RDATA (RDATA),
    .RDONE (RDONE), .COUNT (COUNT), .OVF (OVF), .TRUNC (TRUNC)
  );

  always #5 CLK = ~CLK;

  int ntests = 0;
  int nfail  = 0;

  // Reference model: FIFO of whole lines (flat pixel queue + length queue).
  logic [DW-1:0] mq[$];
  int            mlen[$];
  bit            m_ovf, m_trunc;
  logic [DW-1:0] lb[64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One pixel period: CE high on the first of seven CLKs, DE/PIX held throughout.
  task automatic pix_cycle(input logic de, input logic [DW-1:0] d, input logic rd);
    for (int k = 0; k < 7; k++) begin
      @(negedge CLK);
      CE    = (k == 0);
      RDONE = rd && (k == 0);
      DE    = de;
      PIX   = d;
    end
  endtask

  task automatic model_pop();
    int n;
    n = mlen.pop_front();
    for (int i = 0; i < n; i++) void'(mq.pop_front());
  endtask

  task automatic model_clear();
    mq.delete();
    mlen.delete();
    m_ovf   = 1'b0;
    m_trunc = 1'b0;
  endtask

  // Drive lb[0..n-1] as one line; optionally pulse RDONE on the commit CE.
  task automatic send_line(input int n, input bit rd);
    bit full, had;
    full = (mlen.size() >= NLINES);
    had  = (mlen.size() > 0);
    for (int i = 0; i < n; i++) pix_cycle(1'b1, lb[i], 1'b0);
    pix_cycle(1'b0, '0, rd);
    if (full) begin
      m_ovf = 1'b1;
    end else begin
      int kept;
      kept = (n > LINE_W) ? LINE_W : n;
      if (n > LINE_W) m_trunc = 1'b1;
      for (int i = 0; i < kept; i++) mq.push_back(lb[i]);
      mlen.push_back(kept);
    end
    if (rd && had) model_pop();
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) lb[i] = DW'($urandom);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_rvalid"}, 32'(RVALID), 32'(mlen.size() != 0));
    check({tag, "_count"},  32'(COUNT),  32'(mlen.size()));
    check({tag, "_ovf"},    32'(OVF),    32'(m_ovf));
    check({tag, "_trunc"},  32'(TRUNC),  32'(m_trunc));
    if (mlen.size() != 0) check({tag, "_rlen"}, 32'(RLEN), 32'(mlen[0]));
  endtask

  // Read every pixel of the oldest line, then release it.
  task automatic read_oldest(input string tag);
    check_status(tag);
    for (int i = 0; i < mlen[0]; i++) begin
      @(negedge CLK);
      RADDR = (LW-1)'(i);
      @(negedge CLK);
      check($sformatf("%s_px%0d", tag, i), 32'(RDATA), 32'(mq[i]));
    end
    @(negedge CLK);
    RDONE = 1'b1;
    @(negedge CLK);
    RDONE = 1'b0;
    model_pop();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rvalid"}, 32'(RVALID), 32'd0);
    check({tag, "_rlen"},   32'(RLEN),   32'd0);
    check({tag, "_rdata"},  32'(RDATA),  32'd0);
    check({tag, "_count"},  32'(COUNT),  32'd0);
    check({tag, "_ovf"},    32'(OVF),    32'd0);
    check({tag, "_trunc"},  32'(TRUNC),  32'd0);
  endtask

  initial begin
    nRES = 1'b0; CE = 1'b0; DE = 1'b0; PIX = '0; CLR = 1'b0; RDONE = 1'b0; RADDR = '0;
    model_clear();
    #12;
    check_all_zero("reset");
    @(negedge CLK);
    nRES = 1'b1;

    // Basic capture: three 10-pixel lines, PIX = line*16 + index.
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 10; i++) lb[i] = DW'(l * 16 + i);
      send_line(10, 1'b0);
    end
    check("basic_count3", 32'(COUNT), 32'd3);
    check("basic_rlen10", 32'(RLEN), 32'd10);
    read_oldest("basic_l0");
    @(negedge CLK);
    RADDR = (LW-1)'(4);
    @(negedge CLK);
    check("basic_l1_px4", 32'(RDATA), 32'h14);
    read_oldest("basic_l1");
    read_oldest("basic_l2");
    check_status("basic_empty");

    // Full: five lines, no reads; the fifth is dropped.
    for (int l = 0; l < 5; l++) begin
      int n;
      n = $urandom_range(1, 12);
      fill_rand(n);
      send_line(n, 1'b0);
    end
    check("full_count4", 32'(COUNT), 32'd4);
    check("full_ovf", 32'(OVF), 32'd1);
    for (int l = 0; l < 4; l++) read_oldest($sformatf("full_l%0d", l));
    check("full_drain_count", 32'(COUNT), 32'd0);
    check("full_drain_rvalid", 32'(RVALID), 32'd0);

    // Truncate: 20-pixel line into 16-pixel slots.
    fill_rand(20);
    send_line(20, 1'b0);
    check("trunc_rlen", 32'(RLEN), 32'(LINE_W));
    check("trunc_flag", 32'(TRUNC), 32'd1);
    read_oldest("trunc");

    // Commit and release on the same CLK with two lines held.
    for (int l = 0; l < 2; l++) begin
      fill_rand(5 + l);
      send_line(5 + l, 1'b0);
    end
    fill_rand(7);
    send_line(7, 1'b1);
    check("simul_count2", 32'(COUNT), 32'd2);
    read_oldest("simul_a");
    read_oldest("simul_b");

    // Wrap: nine lines through the ring, read one by one.
    for (int l = 0; l < 9; l++) begin
      int n;
      n = $urandom_range(1, LINE_W);
      fill_rand(n);
      send_line(n, 1'b0);
      read_oldest($sformatf("wrap_l%0d", l));
    end

    // DE toggling with CE low must not store or commit anything.
    for (int k = 0; k < 24; k++) begin
      @(negedge CLK);
      CE = 1'b0;
      DE = k[0];
      PIX = DW'($urandom);
    end
    @(negedge CLK);
    DE = 1'b0;
    @(negedge CLK);
    check_status("ce0");
    fill_rand(6);
    send_line(6, 1'b0);
    read_oldest("ce0_after");

    // CLR in mid-line: flags and slots cleared, rest of line skipped.
    fill_rand(4);
    send_line(4, 1'b0);
    for (int i = 0; i < 3; i++) pix_cycle(1'b1, DW'($urandom), 1'b0);
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    model_clear();
    check_all_zero("clr");
    for (int i = 0; i < 3; i++) pix_cycle(1'b1, DW'($urandom), 1'b0);
    pix_cycle(1'b0, '0, 1'b0);
    check_status("clr_skipped");
    fill_rand(9);
    send_line(9, 1'b0);
    read_oldest("clr_next");

    // Async reset in mid-line.
    for (int l = 0; l < 2; l++) begin
      fill_rand(3);
      send_line(3, 1'b0);
    end
    for (int i = 0; i < 2; i++) pix_cycle(1'b1, DW'($urandom), 1'b0);
    @(negedge CLK);
    #2;
    nRES = 1'b0;
    #1;
    check_all_zero("areset");
    for (int i = 0; i < 2; i++) pix_cycle(1'b1, DW'($urandom), 1'b0);
    pix_cycle(1'b0, '0, 1'b0);
    @(negedge CLK);
    nRES = 1'b1;
    model_clear();
    check_status("areset_after");
    fill_rand(11);
    send_line(11, 1'b0);
    read_oldest("areset_next");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
